axonerve_kvs_traffic_gen: RTL

//  Synthesizable, parametrised command sequencer and checker for axonerve_kvs_kernel. Replaces the fixed

---
 rtl/axonerve_kvs_traffic_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axonerve_kvs_traffic_gen.sv
// Command sequencer and ACK checker for axonerve_kvs_kernel: runs write/search/update/erase phases
// over NUM_KEYS seed-derived keys with backpressure, an outstanding limit and an in-order check FIFO.
module axonerve_kvs_traffic_gen #(
  parameter int unsigned KEY_W    = 128,
  parameter int unsigned VAL_W    = 32,
  parameter int unsigned PRI_W    = 7,
  parameter int unsigned NUM_KEYS = 16,
  parameter int unsigned MAX_OUT  = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_START,
  input  logic [31:0]      I_SEED,
  input  logic             I_KVS_READY,
  input  logic             I_KVS_CMD_FULL,
  input  logic             I_KVS_ACK,
  input  logic             I_KVS_ENT_ERR,
  input  logic             I_KVS_SINGLE_HIT,
  input  logic             I_KVS_MULTI_HIT,
  input  logic [VAL_W-1:0] I_KVS_KEY_VALUE,
  output logic             O_KVS_CMD_VALID,
  output logic [4:0]       O_KVS_CMD_OP,
  output logic [KEY_W-1:0] O_KVS_KEY_DAT,
  output logic [KEY_W-1:0] O_KVS_EKEY_MSK,
  output logic [PRI_W-1:0] O_KVS_KEY_PRI,
  output logic [VAL_W-1:0] O_KVS_KEY_VALUE,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_PASS,
  output logic [CNT_W-1:0] O_CMD_CNT,
  output logic [CNT_W-1:0] O_ACK_CNT,
  output logic [CNT_W-1:0] O_ERR_CNT
);
  localparam int unsigned IDX_W = $clog2(NUM_KEYS + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned REP   = KEY_W / 32;

  localparam logic [4:0] OpErase  = 5'b10000;
  localparam logic [4:0] OpWrite  = 5'b01000;
  localparam logic [4:0] OpSearch = 5'b00010;
  localparam logic [4:0] OpUpdate = 5'b00001;

  localparam logic [2:0] PhWr = 3'd0, PhSr0 = 3'd1, PhUpd = 3'd2;
  localparam logic [2:0] PhSr1 = 3'd3, PhErs = 3'd4, PhSr2 = 3'd5;

  typedef enum logic [3:0] {
    StIdle, StWaitRdy, StWr, StSr0, StUpd, StSr1, StErs, StSr2, StDrain, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      seed_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cmd_cnt_q, ack_cnt_q, err_cnt_q;
  logic             cmd_valid_q;
  logic [4:0]       cmd_op_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [2:0]       fifo_ph_q  [MAX_OUT];
  logic [IDX_W-1:0] fifo_idx_q [MAX_OUT];

  logic             busy, in_issue, issue, pop, timeout, start_ok, mismatch, err_inc, barrier;
  logic [2:0]       phase, head_ph;
  logic [IDX_W-1:0] head_idx;
  logic [31:0]      w_iss, w_chk;
  logic [4:0]       op_iss;
  logic [VAL_W-1:0] val_iss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    busy     = !(state_q inside {StIdle, StDone});
    start_ok = I_START && !busy;
    in_issue = 1'b1;
    phase    = PhWr;
    unique case (state_q)
      StWr:    phase = PhWr;
      StSr0:   phase = PhSr0;
      StUpd:   phase = PhUpd;
      StSr1:   phase = PhSr1;
      StErs:   phase = PhErs;
      StSr2:   phase = PhSr2;
      default: in_issue = 1'b0;
    endcase

    timeout = busy && (out_q != '0) && !I_KVS_ACK && (to_q == TO_W'(TIMEOUT - 1));
    to_d    = (busy && (out_q != '0) && !I_KVS_ACK) ? to_q + TO_W'(1) : '0;
    issue   = in_issue && (idx_q < IDX_W'(NUM_KEYS)) && !I_KVS_CMD_FULL &&
              (out_q < OUT_W'(MAX_OUT)) && !timeout;
    pop     = I_KVS_ACK && (out_q != '0);
    barrier = (idx_q == IDX_W'(NUM_KEYS)) && (out_q == '0);

    w_iss   = seed_q + 32'(idx_q);
    op_iss  = OpSearch;
    val_iss = '0;
    unique case (phase)
      PhWr:  begin op_iss = OpWrite;  val_iss = VAL_W'(~w_iss); end
      PhUpd: begin op_iss = OpUpdate; val_iss = VAL_W'(w_iss ^ 32'h5a5a5a5a); end
      PhErs: op_iss = OpErase;
      default: op_iss = OpSearch;
    endcase

    head_ph  = fifo_ph_q[rd_ptr_q];
    head_idx = fifo_idx_q[rd_ptr_q];
    w_chk    = seed_q + 32'(head_idx);
    unique case (head_ph)
      PhWr, PhUpd, PhErs: mismatch = I_KVS_ENT_ERR;
      PhSr0: mismatch = !I_KVS_SINGLE_HIT || I_KVS_MULTI_HIT ||
                        (I_KVS_KEY_VALUE != VAL_W'(~w_chk));
      PhSr1: mismatch = !I_KVS_SINGLE_HIT || I_KVS_MULTI_HIT ||
                        (I_KVS_KEY_VALUE != VAL_W'(w_chk ^ 32'h5a5a5a5a));
      PhSr2: mismatch = I_KVS_SINGLE_HIT || I_KVS_MULTI_HIT;
      default: mismatch = 1'b1;
    endcase
    // An ACK with nothing outstanding is always an error and never pops.
    err_inc = (I_KVS_ACK && ((out_q == '0) || mismatch)) || timeout;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + IDX_W'(issue);
    unique case (state_q)
      StIdle, StDone: if (I_START) state_d = StWaitRdy;
      StWaitRdy: if (I_KVS_READY) state_d = StWr;
      StWr:      if (barrier) state_d = StSr0;
      StSr0:     if (barrier) state_d = StUpd;
      StUpd:     if (barrier) state_d = StSr1;
      StSr1:     if (barrier) state_d = StErs;
      StErs:     if (barrier) state_d = StSr2;
      StSr2:     if (barrier) state_d = StDrain;
      StDrain:   if (out_q == '0) state_d = StDone;
      default:   state_d = StIdle;
    endcase
    if ((in_issue && barrier) || start_ok) idx_d = '0;
    if (timeout) state_d = StDone;

    out_d = out_q + OUT_W'(issue) - OUT_W'(pop);
    if (start_ok || timeout) out_d = '0;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      to_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_cnt_q   <= '0;
      ack_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      key_q       <= '0;
      val_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      to_q        <= to_d;
      cmd_valid_q <= issue;
      cmd_op_q    <= issue ? op_iss : '0;
      key_q       <= issue ? {REP{w_iss}} : '0;
      val_q       <= issue ? val_iss : '0;
      if (start_ok) seed_q <= I_SEED;
      if (start_ok || timeout) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (issue) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (start_ok) begin
        cmd_cnt_q <= '0;
        ack_cnt_q <= '0;
        err_cnt_q <= '0;
      end else begin
        if (issue)     cmd_cnt_q <= sat_inc(cmd_cnt_q);
        if (I_KVS_ACK) ack_cnt_q <= sat_inc(ack_cnt_q);
        if (err_inc)   err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (issue) begin
      fifo_ph_q[wr_ptr_q]  <= phase;
      fifo_idx_q[wr_ptr_q] <= idx_q;
    end
  end

  assign O_KVS_CMD_VALID = cmd_valid_q;
  assign O_KVS_CMD_OP    = cmd_op_q;
  assign O_KVS_KEY_DAT   = key_q;
  assign O_KVS_EKEY_MSK  = '0;
  assign O_KVS_KEY_PRI   = '0;
  assign O_KVS_KEY_VALUE = val_q;
  assign O_BUSY          = busy;
  assign O_DONE          = (state_q == StDone);
  assign O_PASS          = (state_q == StDone) && (err_cnt_q == '0);
  assign O_CMD_CNT       = cmd_cnt_q;
  assign O_ACK_CNT       = ack_cnt_q;
  assign O_ERR_CNT       = err_cnt_q;

endmodule
